// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port BRAM between instruction fetch (I) and data (D) ports.
// D wins by default; a grant streak limit guarantees fetch forward progress.
module imem_dmem_arbiter #(
  parameter int MEM_AW     = 10,
  parameter int STREAK_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_I_RD = 2'd1;
  localparam logic [1:0] ST_D_RD = 2'd2;
  localparam logic [1:0] ST_D_WR = 2'd3;

  localparam logic [3:0] LP_STREAK_MAX = 4'(STREAK_MAX);

  logic [1:0]       r_state;
  logic [3:0]       r_streak;
  logic [CNT_W-1:0] r_conflict;

  logic w_streak_full;
  logic w_d_gnt;
  logic w_i_gnt;
  logic w_unused;

  // Grants are masked by rst so nothing reaches the BRAM while in reset.
  assign w_streak_full = (r_streak == LP_STREAK_MAX);
  assign w_d_gnt       = ~rst & d_req & ~(i_req & w_streak_full);
  assign w_i_gnt       = ~rst & i_req & ~w_d_gnt;

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_i_gnt | w_d_gnt;
  assign mem_addr  = w_d_gnt ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
  assign mem_we    = (w_d_gnt & d_we) ? d_be : 4'b0000;
  assign mem_wdata = d_wdata;

  assign i_rvalid     = (r_state == ST_I_RD);
  assign d_rvalid     = (r_state == ST_D_RD);
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign conflict_cnt = r_conflict;

  assign w_unused = &{1'b0, i_addr[31:MEM_AW+2], i_addr[1:0], d_addr[31:MEM_AW+2], d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_streak   <= 4'd0;
      r_conflict <= '0;
    end else begin
      if (w_i_gnt) begin
        r_state <= ST_I_RD;
      end else if (w_d_gnt) begin
        r_state <= d_we ? ST_D_WR : ST_D_RD;
      end else begin
        r_state <= ST_IDLE;
      end

      if (w_i_gnt | ~i_req) begin
        r_streak <= 4'd0;
      end else if (w_d_gnt && !w_streak_full) begin
        r_streak <= r_streak + 4'd1;
      end

      if (i_req & d_req & ~&r_conflict) begin
        r_conflict <= r_conflict + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: directed scenarios plus randomized
// requesters, checked against a shadow-memory reference model.
module tb_imem_dmem_arbiter;
  localparam int AW   = 10;
  localparam int SMAX = 4;

  typedef struct {
    bit          iv;
    bit          dv;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0]   i_rdata, d_rdata, mem_wdata;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   conflict_cnt;
  logic [31:0]   mem_rdata = '0;

  logic          w4_i_gnt, w4_i_rvalid, w4_d_gnt, w4_d_rvalid, w4_mem_en;
  logic [31:0]   w4_i_rdata, w4_d_rdata, w4_mem_wdata;
  logic [3:0]    w4_mem_we;
  logic [AW-1:0] w4_mem_addr;
  logic [3:0]    w4_conflict_cnt;

  imem_dmem_arbiter #(.MEM_AW(AW), .STREAK_MAX(SMAX), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  imem_dmem_arbiter #(.MEM_AW(AW), .STREAK_MAX(SMAX), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(w4_i_gnt), .i_rvalid(w4_i_rvalid), .i_rdata(w4_i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(w4_d_gnt), .d_rvalid(w4_d_rvalid), .d_rdata(w4_d_rdata),
    .mem_en(w4_mem_en), .mem_we(w4_mem_we), .mem_addr(w4_mem_addr), .mem_wdata(w4_mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(w4_conflict_cnt)
  );

  // The physical BRAM the arbiter drives.
  logic [31:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (|mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= bram[mem_addr];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int   m_streak = 0;
  int   m_cnt = 0;
  int   m_cnt4 = 0;
  bit   last_i = 0;
  bit   last_d = 0;
  exp_t q[$];
  exp_t me;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: inputs already driven; returns just after the edge.
  task automatic step();
    logic          egi, egd;
    logic [AW-1:0] wa;
    exp_t          e;
    @(negedge clk);
    if (rst) begin
      egi = 1'b0;
      egd = 1'b0;
    end else begin
      egd = d_req && !(i_req && m_streak == SMAX);
      egi = i_req && !egd;
    end
    chk("i_gnt", 32'(i_gnt), 32'(egi));
    chk("d_gnt", 32'(d_gnt), 32'(egd));
    chk("mem_en", 32'(mem_en), 32'(egi | egd));
    chk("mem_we", 32'(mem_we), (egd && d_we) ? 32'(d_be) : 32'd0);
    wa = egd ? d_addr[AW+1:2] : i_addr[AW+1:2];
    if (egi || egd) chk("mem_addr", 32'(mem_addr), 32'(wa));
    e.iv   = egi;
    e.dv   = egd && !d_we;
    e.data = ref_mem[wa];
    q.push_back(e);
    if (egd && d_we)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) ref_mem[wa][8*b +: 8] = d_wdata[8*b +: 8];
    if (rst) begin
      m_streak = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (egi || !i_req) m_streak = 0;
      else if (egd && m_streak < SMAX) m_streak++;
      if (i_req && d_req) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    last_i = egi;
    last_d = egd;
    @(posedge clk);
    #1;
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    chk("conflict_cnt_w4", 32'(w4_conflict_cnt), 32'(m_cnt4));
  endtask

  // Monitor: each cycle's response is compared against the entry queued at its grant.
  always @(posedge clk) begin
    #3;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("i_rvalid", 32'(i_rvalid), 32'(me.iv));
      chk("d_rvalid", 32'(d_rvalid), 32'(me.dv));
      if (me.iv) chk("i_rdata", i_rdata, me.data);
      if (me.dv) chk("d_rdata", d_rdata, me.data);
    end else if (i_rvalid || d_rvalid) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_rvalid: got i=%b d=%b expected none", i_rvalid, d_rvalid);
    end
  end

  logic [5:0]  gpat;
  logic [31:0] old_w2;

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      ref_mem[k] = $urandom;
      bram[k]    = ref_mem[k];
    end
    ref_mem[4] = 32'hDEADBEEF;
    bram[4]    = 32'hDEADBEEF;

    // Reset state: outputs quiet even with both requesters active.
    i_req = 1; d_req = 1; d_we = 1; d_be = 4'hF; i_addr = 32'h40; d_addr = 32'h44;
    #1;
    chk("rst_i_gnt", 32'(i_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rvalid", 32'({i_rvalid, d_rvalid}), 0);
    repeat (2) step();
    rst = 0; i_req = 0; d_req = 0; d_we = 0;
    step();

    // I only, word 4.
    i_req = 1; i_addr = 32'h10;
    repeat (3) step();
    i_req = 0;

    // Conflict load: D wins, I served afterwards.
    i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h20;
    step();
    d_req = 0;
    step();
    i_req = 0;
    step();

    // Starvation bound: D x4, I x1, D again.
    i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h30; i_addr = 32'h34;
    for (int c = 0; c < 6; c++) begin
      step();
      gpat[c] = last_d;
    end
    chk("streak_pattern", 32'(gpat), 32'b101111);
    i_req = 0; d_req = 0;
    step();

    // Partial store then load of the same word.
    old_w2 = ref_mem[2];
    d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'h12345678; d_addr = 32'h8;
    step();
    chk("store_merge_model", ref_mem[2], {old_w2[31:16], 16'h5678});
    d_we = 0;
    step();
    d_req = 0;
    step();

    // Randomized requesters that hold until granted.
    for (int c = 0; c < 400; c++) begin
      if (!i_req || last_i) begin
        i_req  = ($urandom % 4) != 0;
        i_addr = ($urandom_range(0, 63) << 2) | ($urandom & 3);
      end
      if (!d_req || last_d) begin
        d_req   = ($urandom % 3) != 0;
        d_we    = ($urandom % 2) != 0;
        d_be    = 4'($urandom);
        d_wdata = $urandom;
        d_addr  = ($urandom_range(0, 63) << 2) | ($urandom & 3);
      end
      step();
    end
    i_req = 0; d_req = 0;
    step();

    // Reset in the cycle after a fetch grant.
    i_req = 1; i_addr = 32'h14;
    step();
    q[q.size()-1].iv = 1'b0;
    rst = 1; i_req = 0;
    m_streak = 0; m_cnt = 0; m_cnt4 = 0;
    #1;
    chk("rst_kills_rvalid", 32'(i_rvalid), 0);
    i_req = 1; d_req = 1; d_we = 0;
    repeat (2) step();
    rst = 0; i_req = 0; d_req = 0;
    chk("post_rst_conflict", 32'(conflict_cnt), 0);
    step();

    // Saturation of a 4-bit conflict counter.
    i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h50; i_addr = 32'h54;
    repeat (23) step();
    chk("cnt4_saturated", 32'(w4_conflict_cnt), 32'hF);
    i_req = 0; d_req = 0;
    step();

    @(posedge clk);
    #5;
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
